btn_debounce: RTL and testbench

BTN_DEBOUNCE -- requirements
Module: btn_debounce

---
 rtl/btn_debounce.sv | 161 ++++++++++++++++
 tb/tb_btn_debounce.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// Multi-channel push-button debouncer: 2-flop input synchronizers, tick edge strobe,
// per-channel qualify FSM. Define KEY_REPEAT_EN to enable auto-repeat press pulses while held.
module btn_debounce_ch #(
  parameter int STABLE_TICKS = 4
`ifdef KEY_REPEAT_EN
  , parameter int REPEAT_TICKS = 16
`endif
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick,
  input  logic btn,
  output logic level,
  output logic press,
  output logic rel
);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  localparam logic [7:0] STABLE = 8'(STABLE_TICKS);
`ifdef KEY_REPEAT_EN
  localparam logic [7:0] REPEAT = 8'(REPEAT_TICKS);
`endif

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt, cnt_inc;
  logic       level_nxt, press_nxt, rel_nxt;

  assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      level <= level_nxt;
      press <= press_nxt;
      rel   <= rel_nxt;
    end
  end

  // A level change is checked before the tick, so a coinciding tick is dropped.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:
        if (btn) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      PRESS_WAIT:
        if (!btn) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (tick) begin
          cnt_nxt = cnt_inc;
          if (cnt_inc >= STABLE) begin
            state_nxt = HELD;
            cnt_nxt   = '0;
          end
        end
      HELD:
        if (!btn) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
`ifdef KEY_REPEAT_EN
        else if (tick) begin
          cnt_nxt = (cnt_inc >= REPEAT) ? 8'd0 : cnt_inc;
        end
`endif
      RELEASE_WAIT:
        if (btn) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (tick) begin
          cnt_nxt = cnt_inc;
          if (cnt_inc >= STABLE) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    level_nxt = (state_nxt == HELD) || (state_nxt == RELEASE_WAIT);
    press_nxt = (state == PRESS_WAIT) && btn && tick && (cnt_inc >= STABLE);
`ifdef KEY_REPEAT_EN
    if ((state == HELD) && btn && tick && (cnt_inc >= REPEAT)) press_nxt = 1'b1;
`endif
    rel_nxt   = (state == RELEASE_WAIT) && !btn && tick && (cnt_inc >= STABLE);
  end
endmodule

module btn_debounce #(
  parameter int N_BTN        = 9,
  parameter int STABLE_TICKS = 4,
  parameter int REPEAT_TICKS = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic [N_BTN-1:0] btn_i,
  output logic [N_BTN-1:0] btn_level_o,
  output logic [N_BTN-1:0] btn_press_o,
  output logic [N_BTN-1:0] btn_release_o
);
  logic [N_BTN-1:0] btn_s1, btn_s2;
  logic             tick_s1, tick_s2, tick_d, tick_stb;

  if (STABLE_TICKS < 1 || STABLE_TICKS > 255 || REPEAT_TICKS < 1 || REPEAT_TICKS > 255) begin : g_bad_param
    $error("btn_debounce: tick parameters must be in 1..255");
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      btn_s1  <= '0;
      btn_s2  <= '0;
      tick_s1 <= 1'b0;
      tick_s2 <= 1'b0;
      tick_d  <= 1'b0;
    end else begin
      btn_s1  <= btn_i;
      btn_s2  <= btn_s1;
      tick_s1 <= tick_i;
      tick_s2 <= tick_s1;
      tick_d  <= tick_s2;
    end
  end

  // Strobe is decoded from flops and lines up with the btn_s2 stage, so tick and
  // button edges entering together reach the FSMs in the same cycle.
  assign tick_stb = tick_s2 & ~tick_d;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .STABLE_TICKS(STABLE_TICKS)
`ifdef KEY_REPEAT_EN
      , .REPEAT_TICKS(REPEAT_TICKS)
`endif
    ) u_ch (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .tick  (tick_stb),
      .btn   (btn_s2[g]),
      .level (btn_level_o[g]),
      .press (btn_press_o[g]),
      .rel   (btn_release_o[g])
    );
  end
endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce: expected press/release events (channel and tick
// index) are queued as stimulus is driven and matched against DUT pulses.
module tb_btn_debounce;
  localparam int N = 9;

  logic         clk = 1'b0, rst_n = 1'b0, tick = 1'b0;
  logic [N-1:0] btn = '0;
  logic [N-1:0] level, press, rel;

  btn_debounce dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .tick_i       (tick),
    .btn_i        (btn),
    .btn_level_o  (level),
    .btn_press_o  (press),
    .btn_release_o(rel)
  );

  always #5 clk = ~clk;

  // Tick: period 20 clk, high for phases 0..9; tick_rises counts 0->1 edges.
  int phase = 19;
  int tick_rises = 0;
  initial forever begin
    @(posedge clk); #3;
    phase = (phase == 19) ? 0 : phase + 1;
    tick  = (phase < 10);
    if (phase == 0) tick_rises++;
  end

  typedef struct {bit rel; int ch; int tk;} exp_t;
  exp_t sb[$];
  int n_vec = 0, n_err = 0;

  task automatic chk(string tag, int obs, int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push(bit r, int c, int tk);
    exp_t e;
    e.rel = r; e.ch = c; e.tk = tk;
    sb.push_back(e);
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_phase(int p);
    do @(negedge clk); while (phase != p);
  endtask

  task automatic wait_ticks(int target);
    int k = 0;
    while (tick_rises < target && k < 2000) begin @(negedge clk); k++; end
    chk("tick_wait", int'(tick_rises >= target), 1);
  endtask

  task automatic drain(int maxc);
    int k = 0;
    while (sb.size() != 0 && k < maxc) begin @(negedge clk); k++; end
    chk("drain", sb.size(), 0);
    sb.delete();
  endtask

  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    for (int c = 0; c < N; c++) begin
      if (press[c] | rel[c]) begin
        chk("excl", int'(press[c] & rel[c]), 0);
        if (sb.size() == 0) chk("spurious_ch", c, -1);
        else begin
          e = sb.pop_front();
          chk("kind", int'(rel[c]), int'(e.rel));
          chk("chan", c, e.ch);
          chk("tick", tick_rises, e.tk);
        end
      end
    end
  end

  initial begin
    int b;
    rst_n = 1'b0;
    idle(3);
    chk("rst_lvl", int'(level), 0);
    chk("rst_prs", int'(press), 0);
    chk("rst_rel", int'(rel), 0);
    wait_phase(5); rst_n = 1'b1;

    // long hold on ch0: single press
    wait_phase(5); btn[0] = 1'b1; push(0, 0, tick_rises + 4);
    idle(200); drain(10);
    chk("lvl_hold0", int'(level), 'h001);

    // short glitch on ch4: rejected
    wait_phase(5); btn[4] = 1'b1; idle(50); btn[4] = 1'b0; idle(120);
    chk("lvl_glitch4", int'(level), 'h001);

    // ch2: press, brief drop (no release), full release
    wait_phase(5); btn[2] = 1'b1; push(0, 2, tick_rises + 4);
    idle(120); drain(10);
    chk("lvl_press2", int'(level), 'h005);
    wait_phase(5); btn[2] = 1'b0; idle(30); btn[2] = 1'b1; idle(60);
    chk("lvl_drop2", int'(level), 'h005);
    wait_phase(5); btn[2] = 1'b0; push(1, 2, tick_rises + 4);
    idle(120); drain(10);
    chk("lvl_rel2", int'(level), 'h001);

    // reset mid-qualification on ch1 with ch0 still held
    wait_phase(5); btn[1] = 1'b1; b = tick_rises;
    wait_ticks(b + 3); idle(5);
    rst_n = 1'b0; idle(1);
    chk("rst2_lvl", int'(level), 0);
    chk("rst2_prs", int'(press), 0);
    chk("rst2_rel", int'(rel), 0);
    idle(4); rst_n = 1'b1;
    push(0, 0, tick_rises + 4); push(0, 1, tick_rises + 4);
    idle(110); drain(10);
    chk("lvl_rst_req", int'(level), 'h003);

    wait_phase(5); btn = '0;
    push(1, 0, tick_rises + 4); push(1, 1, tick_rises + 4);
    idle(120); drain(10);
    chk("lvl_allrel", int'(level), 0);

    // ch3: btn edge coincides with tick edge, that tick is not counted
    wait_phase(0); btn[3] = 1'b1; push(0, 3, tick_rises + 4);
    idle(120); drain(10);
    chk("lvl_coinc3", int'(level), 'h008);
    wait_phase(5); btn[3] = 1'b0; push(1, 3, tick_rises + 4);
    idle(120); drain(10);

    // ch8: hold for 40 ticks
    wait_phase(5); btn[8] = 1'b1; b = tick_rises;
    push(0, 8, b + 4);
`ifdef KEY_REPEAT_EN
    push(0, 8, b + 20);
    push(0, 8, b + 36);
`endif
    wait_ticks(b + 40); idle(5); drain(10);
    chk("lvl_hold8", int'(level), 'h100);
    btn[8] = 1'b0; push(1, 8, tick_rises + 4);
    idle(120); drain(10);
    chk("lvl_end", int'(level), 0);

    idle(20);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
